// File: rtl/ro_puf_scheduler.sv
// Ring-oscillator PUF evaluation sequencer: arbitrates requesters, steps each RO through
// clear/measure/settle/capture, and returns the pairwise count-comparison response word.
module ro_puf_scheduler #(
   parameter int NUM_RO  = 9,
   parameter int NUM_REQ = 2,
   parameter int WINDOW  = 'hFFFFFF,
   parameter int SETTLE  = 4,
   parameter int CNT_W   = 32,
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [NUM_REQ-1:0]     REQ_VALID,
   input  logic [NUM_REQ*8-1:0]   REQ_CHALLENGE,
   output logic [NUM_REQ-1:0]     REQ_READY,
   output logic                   RSP_VALID,
   input  logic                   RSP_READY,
   output logic [ID_W-1:0]        RSP_ID,
   output logic [NUM_RO-2:0]      RSP_DATA,
   output logic [NUM_RO-1:0]      RO_EN,
   output logic [5:0]             RO_CHALLENGE,
   output logic                   CNT_CLR,
   input  logic [CNT_W-1:0]       CNT_IN,
   output logic                   BUSY
);

   localparam int T_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam int RW    = $clog2(NUM_RO);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_MEASURE = 3'd2;
   localparam logic [2:0] S_SETTLE  = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;
   localparam logic [2:0] S_RESPOND = 3'd5;

   logic [2:0]        r_state;
   logic [ID_W-1:0]   r_ptr;
   logic [RW-1:0]     r_ro;
   logic [TW-1:0]     r_timer;
   logic [5:0]        r_chal;
   logic [ID_W-1:0]   r_id;
   logic              r_rsp_valid;
   logic [NUM_RO-2:0] r_rsp_data;
   logic [CNT_W-1:0]  r_cnt [NUM_RO];

   logic              w_gnt_found;
   logic [ID_W-1:0]   w_gnt_idx;
   logic [NUM_RO-2:0] w_rsp_next;

   // Round-robin search starting at the pointer, wrapping around the requester list.
   always_comb begin
      int idx;
      idx         = 0;
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_gnt_found && REQ_VALID[idx]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = ID_W'(idx);
         end
      end
   end

   // Response is formed on the final capture, so the last count comes straight from CNT_IN.
   always_comb begin
      w_rsp_next = '0;
      for (int i = 0; i < NUM_RO-1; i++) begin
         w_rsp_next[i] = r_cnt[i] > ((i == NUM_RO-2) ? CNT_IN : r_cnt[i+1]);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_ro        <= '0;
         r_timer     <= '0;
         r_chal      <= '0;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         for (int i = 0; i < NUM_RO; i++) r_cnt[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_found) begin
                  r_chal  <= REQ_CHALLENGE[{w_gnt_idx, 3'b000} +: 6];
                  r_id    <= w_gnt_idx;
                  r_ptr   <= (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
                  r_ro    <= '0;
                  r_state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_timer <= '0;
               r_state <= S_MEASURE;
            end
            S_MEASURE: begin
               if (r_timer == TW'(WINDOW-1)) begin
                  r_timer <= '0;
                  r_state <= S_SETTLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_SETTLE: begin
               if (r_timer == TW'(SETTLE-1)) begin
                  r_timer <= '0;
                  r_state <= S_CAPTURE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_CAPTURE: begin
               r_cnt[r_ro] <= CNT_IN;
               if (r_ro == RW'(NUM_RO-1)) begin
                  r_rsp_data  <= w_rsp_next;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESPOND;
               end else begin
                  r_ro    <= r_ro + 1'b1;
                  r_state <= S_CLEAR;
               end
            end
            S_RESPOND: begin
               if (RSP_READY) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ_READY    = (r_state == S_IDLE && w_gnt_found && RESET_N)
                         ? (NUM_REQ'(1) << w_gnt_idx) : '0;
   assign RO_EN        = (r_state == S_MEASURE) ? (NUM_RO'(1) << r_ro) : '0;
   assign CNT_CLR      = (r_state == S_CLEAR);
   assign BUSY         = (r_state != S_IDLE);
   assign RSP_VALID    = r_rsp_valid;
   assign RSP_DATA     = r_rsp_data;
   assign RSP_ID       = r_id;
   assign RO_CHALLENGE = r_chal;

endmodule

// File: tb/tb_ro_puf_scheduler.sv
// Directed bench for ro_puf_scheduler with a 3-RO / 2-requester configuration.
module tb_ro_puf_scheduler;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic [1:0]  REQ_VALID = '0;
   logic [15:0] REQ_CHALLENGE = '0;
   logic [1:0]  REQ_READY;
   logic        RSP_VALID;
   logic        RSP_READY = 1'b0;
   logic [0:0]  RSP_ID;
   logic [1:0]  RSP_DATA;
   logic [2:0]  RO_EN;
   logic [5:0]  RO_CHALLENGE;
   logic        CNT_CLR;
   logic [31:0] CNT_IN;
   logic        BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   // Counter model: reports the count of whichever RO was most recently enabled.
   logic [31:0] cnt_tab0 = 32'd100, cnt_tab1 = 32'd50, cnt_tab2 = 32'd75;
   int last_ro = 0;
   always @(posedge CLK) begin
      if (RO_EN == 3'b001) last_ro <= 0;
      else if (RO_EN == 3'b010) last_ro <= 1;
      else if (RO_EN == 3'b100) last_ro <= 2;
   end
   assign CNT_IN = (last_ro == 0) ? cnt_tab0 : (last_ro == 1) ? cnt_tab1 : cnt_tab2;

   always #5 CLK = ~CLK;

   ro_puf_scheduler #(
      .NUM_RO(3), .NUM_REQ(2), .WINDOW(16), .SETTLE(4), .CNT_W(32)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .REQ_VALID(REQ_VALID), .REQ_CHALLENGE(REQ_CHALLENGE),
      .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
      .RSP_DATA(RSP_DATA), .RO_EN(RO_EN), .RO_CHALLENGE(RO_CHALLENGE), .CNT_CLR(CNT_CLR),
      .CNT_IN(CNT_IN), .BUSY(BUSY)
   );

   task automatic apply_reset();
      RESET_N   = 1'b0;
      REQ_VALID = '0;
      RSP_READY = 1'b0;
      @(posedge CLK); @(posedge CLK); #1;
      RESET_N   = 1'b1;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      REQ_VALID = 2'b01;
      #1;
      n_tests++;
      if (REQ_READY !== 2'b00 || RSP_VALID !== 1'b0 || RSP_DATA !== 2'b00 || RSP_ID !== 1'b0 ||
          RO_EN !== 3'b000 || CNT_CLR !== 1'b0 || BUSY !== 1'b0 || RO_CHALLENGE !== 6'h00) begin
         n_fail++;
         $display("FAIL reset_state got rdy=%b vld=%b data=%b id=%b en=%b clr=%b busy=%b ch=%h, want all zero",
                  REQ_READY, RSP_VALID, RSP_DATA, RSP_ID, RO_EN, CNT_CLR, BUSY, RO_CHALLENGE);
      end
      REQ_VALID = 2'b00;
      apply_reset();
   endtask

   task automatic test_basic();
      logic [2:0] exp_en;
      logic       exp_clr;
      apply_reset();
      cnt_tab0 = 32'd100; cnt_tab1 = 32'd50; cnt_tab2 = 32'd75;
      REQ_CHALLENGE = 16'h002A;
      REQ_VALID     = 2'b01;
      #1;
      n_tests++;
      if (REQ_READY !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_grant got REQ_READY=%b want 01", REQ_READY);
      end
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
      n_tests++;
      if (REQ_READY !== 2'b00 || RO_CHALLENGE !== 6'h2A || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_latch got rdy=%b ch=%h busy=%b want 00 2a 1", REQ_READY, RO_CHALLENGE, BUSY);
      end
      for (int k = 0; k < 66; k++) begin
         exp_en  = (k % 22 >= 1 && k % 22 <= 16) ? 3'(1 << (k / 22)) : 3'b000;
         exp_clr = (k % 22 == 0);
         n_tests++;
         if (RO_EN !== exp_en || CNT_CLR !== exp_clr || RSP_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_seq k=%0d got en=%b clr=%b vld=%b want en=%b clr=%b vld=0",
                     k, RO_EN, CNT_CLR, RSP_VALID, exp_en, exp_clr);
         end
         @(posedge CLK); #1;
      end
      n_tests++;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== 2'b01 || RSP_ID !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_rsp got vld=%b data=%b id=%b want 1 01 0", RSP_VALID, RSP_DATA, RSP_ID);
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
      n_tests++;
      if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_handshake got vld=%b busy=%b want 0 0", RSP_VALID, BUSY);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_rdy;
      apply_reset();
      cnt_tab0 = 32'd100; cnt_tab1 = 32'd50; cnt_tab2 = 32'd75;
      REQ_CHALLENGE = 16'h1122;
      REQ_VALID = 2'b11;
      RSP_READY = 1'b1;
      #1;
      for (int e = 0; e < 3; e++) begin
         exp_rdy = (e == 1) ? 2'b10 : 2'b01;
         for (int c = 0; c < 50 && REQ_READY == 2'b00; c++) begin @(posedge CLK); #1; end
         n_tests++;
         if (REQ_READY !== exp_rdy) begin
            n_fail++;
            $display("FAIL b2b_grant e=%0d got REQ_READY=%b want %b", e, REQ_READY, exp_rdy);
         end
         @(posedge CLK); #1;
         for (int c = 0; c < 200 && RSP_VALID !== 1'b1; c++) begin @(posedge CLK); #1; end
         n_tests++;
         if (RSP_VALID !== 1'b1 || RSP_ID !== exp_rdy[1] || RSP_DATA !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_rsp e=%0d got vld=%b id=%b data=%b want 1 %b 01",
                     e, RSP_VALID, RSP_ID, RSP_DATA, exp_rdy[1]);
         end
         @(posedge CLK); #1;
      end
      REQ_VALID = 2'b00;
      RSP_READY = 1'b0;
   endtask

   task automatic test_backpressure();
      apply_reset();
      cnt_tab0 = 32'd10; cnt_tab1 = 32'd20; cnt_tab2 = 32'd5;
      REQ_CHALLENGE = 16'h0C00;
      REQ_VALID = 2'b10;
      #1;
      n_tests++;
      if (REQ_READY !== 2'b10) begin
         n_fail++;
         $display("FAIL bp_grant got REQ_READY=%b want 10", REQ_READY);
      end
      @(posedge CLK); #1;
      REQ_VALID = 2'b11;
      for (int c = 0; c < 200 && RSP_VALID !== 1'b1; c++) begin @(posedge CLK); #1; end
      for (int c = 0; c < 10; c++) begin
         n_tests++;
         if (RSP_VALID !== 1'b1 || RSP_DATA !== 2'b10 || RSP_ID !== 1'b1 || REQ_READY !== 2'b00 ||
             RO_CHALLENGE !== 6'h0C) begin
            n_fail++;
            $display("FAIL bp_hold c=%0d got vld=%b data=%b id=%b rdy=%b ch=%h want 1 10 1 00 0c",
                     c, RSP_VALID, RSP_DATA, RSP_ID, REQ_READY, RO_CHALLENGE);
         end
         @(posedge CLK); #1;
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
      n_tests++;
      if (RSP_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_READY !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_release got vld=%b busy=%b rdy=%b want 0 0 01", RSP_VALID, BUSY, REQ_READY);
      end
      REQ_VALID = 2'b00;
   endtask

   task automatic test_reset_mid();
      bit seen;
      apply_reset();
      cnt_tab0 = 32'd100; cnt_tab1 = 32'd50; cnt_tab2 = 32'd75;
      REQ_CHALLENGE = 16'h002A;
      REQ_VALID = 2'b01;
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
      for (int c = 0; c < 100 && RO_EN !== 3'b010; c++) begin @(posedge CLK); #1; end
      n_tests++;
      if (RO_EN !== 3'b010) begin
         n_fail++;
         $display("FAIL mid_reach_window2 got RO_EN=%b want 010", RO_EN);
      end
      repeat (3) begin @(posedge CLK); #1; end
      RESET_N = 1'b0;
      #1;
      n_tests++;
      if (RO_EN !== 3'b000 || BUSY !== 1'b0 || RSP_VALID !== 1'b0 || RO_CHALLENGE !== 6'h00) begin
         n_fail++;
         $display("FAIL mid_async_reset got en=%b busy=%b vld=%b ch=%h want 000 0 0 00",
                  RO_EN, BUSY, RSP_VALID, RO_CHALLENGE);
      end
      @(posedge CLK); @(posedge CLK); #1;
      RESET_N = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
         @(posedge CLK); #1;
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_no_response got activity=%b want 0", seen);
      end
      REQ_CHALLENGE = 16'h0015;
      REQ_VALID = 2'b01;
      #1;
      n_tests++;
      if (REQ_READY !== 2'b01) begin
         n_fail++;
         $display("FAIL mid_regrant got REQ_READY=%b want 01", REQ_READY);
      end
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
      for (int c = 0; c < 200 && RSP_VALID !== 1'b1; c++) begin @(posedge CLK); #1; end
      n_tests++;
      if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_DATA !== 2'b01 || RO_CHALLENGE !== 6'h15) begin
         n_fail++;
         $display("FAIL mid_next_served got vld=%b id=%b data=%b ch=%h want 1 0 01 15",
                  RSP_VALID, RSP_ID, RSP_DATA, RO_CHALLENGE);
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
   endtask

   task automatic test_equal_counts();
      apply_reset();
      cnt_tab0 = 32'd80; cnt_tab1 = 32'd80; cnt_tab2 = 32'd80;
      REQ_CHALLENGE = 16'h3300;
      REQ_VALID = 2'b10;
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
      for (int c = 0; c < 200 && RSP_VALID !== 1'b1; c++) begin @(posedge CLK); #1; end
      n_tests++;
      if (RSP_VALID !== 1'b1 || RSP_DATA !== 2'b00 || RSP_ID !== 1'b1 || RO_CHALLENGE !== 6'h33) begin
         n_fail++;
         $display("FAIL equal_counts got vld=%b data=%b id=%b ch=%h want 1 00 1 33",
                  RSP_VALID, RSP_DATA, RSP_ID, RO_CHALLENGE);
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
   endtask

   task automatic test_challenge_hold();
      apply_reset();
      cnt_tab0 = 32'd100; cnt_tab1 = 32'd50; cnt_tab2 = 32'd75;
      REQ_CHALLENGE = 16'h00C5;
      REQ_VALID = 2'b01;
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 2'b00;
      REQ_CHALLENGE = 16'hFFFF;
      repeat (30) begin @(posedge CLK); #1; end
      n_tests++;
      if (RO_CHALLENGE !== 6'h05 || BUSY !== 1'b1) begin
         n_fail++;
         $display("FAIL chal_hold_mid got ch=%h busy=%b want 05 1", RO_CHALLENGE, BUSY);
      end
      for (int c = 0; c < 200 && RSP_VALID !== 1'b1; c++) begin @(posedge CLK); #1; end
      n_tests++;
      if (RSP_VALID !== 1'b1 || RO_CHALLENGE !== 6'h05 || RSP_DATA !== 2'b01) begin
         n_fail++;
         $display("FAIL chal_hold_end got vld=%b ch=%h data=%b want 1 05 01",
                  RSP_VALID, RO_CHALLENGE, RSP_DATA);
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_equal_counts();
      test_challenge_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ro_puf_scheduler.md
Name: ro_puf_scheduler

Overview:
- Sequences one shared bank of ring oscillators and their edge counter for several challenge requesters.
- Round-robin arbitrates between requesters and latches the winner's challenge.
- Enables each RO in turn for a fixed window, with a counter clear before each window and a settle gap after it.
- Captures each count, then returns the comparison response word over a valid/ready channel; sits between the system bus side and the RO bank / counter datapath.

Parameters:
- NUM_RO, 9, number of ring oscillators measured per evaluation (≥2).
- NUM_REQ, 2, number of requesters (≥1).
- WINDOW, 'hFFFFFF, CLK cycles each RO is enabled.
- SETTLE, 4, CLK cycles after RO disable before CNT_IN is sampled (≥2; covers counter-domain settling).
- CNT_W, 32, width of CNT_IN and stored counts.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  NUM_REQ  per-requester request.
- REQ_CHALLENGE  in  NUM_REQ*8  per-requester challenge; requester r uses bits [8r+7:8r].
- REQ_READY  out  NUM_REQ  grant/accept strobe, at most one bit high.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumer ready.
- RSP_ID  out  max(1,$clog2(NUM_REQ))  index of the served requester.
- RSP_DATA  out  NUM_RO-1  response bits.
- RO_EN  out  NUM_RO  one-hot RO enable, all-zero outside MEASURE.
- RO_CHALLENGE  out  6  latched challenge[5:0] to the RO delay-select inputs.
- CNT_CLR  out  1  synchronous clear request to the RO edge counter.
- CNT_IN  in  CNT_W  RO edge count, stable while RO_EN is all-zero after SETTLE.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RESET_N low, asynchronous):
  - state IDLE; round-robin pointer 0; current_ro 0; timer 0.
  - All stored counts 0; RO_EN 0, CNT_CLR 0, RSP_VALID 0, RSP_DATA 0, RSP_ID 0, RO_CHALLENGE 0, BUSY 0, REQ_READY 0.
  - Reset mid-evaluation discards the evaluation; no response is emitted.
- FSM: IDLE -> CLEAR -> MEASURE -> SETTLE -> CAPTURE -> (CLEAR | RESPOND) -> IDLE.
- IDLE:
  - REQ_READY is combinational. It is asserted only for the granted requester g, which is the first requester with REQ_VALID set, searching from pointer upward with wrap.
  - On the grant edge: latch challenge[7:0] and g; pointer <= (g+1) mod NUM_REQ; current_ro <= 0; go to CLEAR.
  - With no REQ_VALID, stay in IDLE.
- CLEAR: one cycle, CNT_CLR=1, RO_EN=0, then MEASURE with timer=0.
- MEASURE: RO_EN[current_ro]=1 for exactly WINDOW cycles (timer 0..WINDOW-1), then SETTLE with timer=0.
- SETTLE: RO_EN=0 for exactly SETTLE cycles, then CAPTURE.
- CAPTURE:
  - One cycle: count[current_ro] <= CNT_IN.
  - If current_ro==NUM_RO-1, go to RESPOND; else current_ro++ and go to CLEAR.
- RESPOND:
  - Registered RSP_DATA[i] = (count[i] > count[i+1]), unsigned compare; equal counts give 0.
  - RSP_VALID stays high with RSP_DATA and RSP_ID stable until a cycle with RSP_READY=1; after that edge, RSP_VALID=0 and state is IDLE.
  - A new grant is possible no earlier than the cycle after the handshake.
- Latency: first RSP_VALID cycle occurs NUM_RO*(WINDOW+SETTLE+2) cycles after the grant edge.
- Input changes while BUSY:
  - REQ_CHALLENGE changes have no effect, because the challenge is latched.
  - REQ_VALID changes have no effect; REQ_READY stays 0 for all requesters.
- Timer width is sized to hold WINDOW-1 and SETTLE-1; no wrap inside a phase.
- RO_EN is never multi-hot and never high outside MEASURE.

Test Plan:
- NUM_RO=3, NUM_REQ=2, WINDOW=16, SETTLE=4. REQ_VALID=01, challenge 8'h2A, CNT_IN model 100/50/75 for RO0/1/2.
  -> REQ_READY=01 for one cycle; RO_CHALLENGE=6'h2A.
  -> RO_EN sequence 001, 010, 100, each 16 cycles; CNT_CLR before each window.
  -> RSP_VALID 66 cycles after grant; RSP_DATA=2'b01; RSP_ID=0.
- Both REQ_VALID held high for three back-to-back evaluations, RSP_READY=1.
  -> grants in order 0, 1, 0; RSP_ID matches each grant.
- RSP_READY=0 for 10 cycles in RESPOND.
  -> RSP_VALID and RSP_DATA stable for all 10 cycles; REQ_READY stays 0; IDLE on the cycle after RSP_READY=1.
- RESET_N pulsed low during the second MEASURE window.
  -> RO_EN=0 and BUSY=0 immediately; no RSP_VALID; the next request is served normally.
- Equal counts 80/80/80.
  -> RSP_DATA=2'b00.
- REQ_CHALLENGE changed to 8'hFF mid-evaluation.
  -> RO_CHALLENGE stays at the latched value.
